ram_write_driver: RTL and testbench

Write-back sequencer for one network layer, the counterpart of the RAM read path. After the units finish a layer's summation, this block walks the units in order, selects each unit's accumulated result, saturates it to the RAM word width and writes it to the layer's output region in RAM. It pulses `done` when the last word is committed, so the layer controller can start the next layer's read.

---
 rtl/ram_write_driver_if.sv | 29 ++
 rtl/ram_write_driver.sv | 138 +++++++++++++
 tb/tb_ram_write_driver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_write_driver_if.sv
// Handshake and RAM write bundle between the layer write-back sequencer and its
// surroundings (layer controller, unit result mux, RAM write port).
interface ram_write_driver_if #(
  parameter int UNIT_W = 2,
  parameter int SUM_W  = 20,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [1:0]        layer;
  logic [SUM_W-1:0]  unit_data;
  logic [UNIT_W-1:0] unit_sel;
  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_din;
  logic              RAM_we;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, layer, unit_data,
    output unit_sel, RAM_address, RAM_din, RAM_we, busy, done, err
  );

  modport slave (
    output start, layer, unit_data,
    input  unit_sel, RAM_address, RAM_din, RAM_we, busy, done, err
  );
endinterface

// File: rtl/ram_write_driver.sv
// Layer write-back sequencer: walks the units in order, saturates each accumulated
// sum to the RAM word width and writes it to the layer's output region.
module ram_write_driver #(
  parameter int NUM_UNITS = 4,
  parameter int UNIT_W    = 2,
  parameter int SUM_W     = 20,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int OUT_BASE  = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_write_driver_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_WAIT = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(NUM_UNITS - 1);

  // In range when every bit above the target sign bit equals the sign bit.
  function automatic logic [DATA_W-1:0] sat(input logic [SUM_W-1:0] x);
    logic [SUM_W-DATA_W:0] top;
    logic [DATA_W-1:0]     res;
    top = x[SUM_W-1:DATA_W-1];
    if ((&top) || !(|top)) begin
      res = x[DATA_W-1:0];
    end else if (x[SUM_W-1]) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [UNIT_W-1:0] unit_sel_q, unit_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] base_s;

  assign base_s = ADDR_W'(OUT_BASE) + ADDR_W'(bus.layer) * ADDR_W'(NUM_UNITS);

  // Next-state and next-output logic; pulses (we, done, err) default low.
  always_comb begin
    state_d    = state_q;
    unit_sel_d = unit_sel_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.layer == 2'd3)) begin
          err_d = 1'b1;
        end else if (bus.start) begin
          addr_d     = base_s;
          unit_sel_d = '0;
          busy_d     = 1'b1;
          state_d    = S_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL:  state_d = S_WAIT;
      S_WAIT: state_d = S_CAP;
      S_CAP: begin
        din_d   = sat(bus.unit_data);
        we_d    = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        addr_d     = addr_q + ADDR_W'(1);
        unit_sel_d = unit_sel_q + UNIT_W'(1);
        if (unit_sel_q == LAST_UNIT) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SEL;
        end
      end
      S_DONE: begin
        busy_d     = 1'b0;
        unit_sel_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        unit_sel_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      unit_sel_q <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_sel_q <= unit_sel_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.unit_sel    = unit_sel_q;
  assign bus.RAM_address = addr_q;
  assign bus.RAM_din     = din_q;
  assign bus.RAM_we      = we_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ram_write_driver.sv
// Scoreboard bench for ram_write_driver: directed runs push expected writes and
// done pulses (with their cycle numbers); a negedge monitor pops and compares.
module tb_ram_write_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_write_driver_if #(.UNIT_W(2), .SUM_W(20), .DATA_W(16), .ADDR_W(10)) bus ();

  ram_write_driver #(
    .NUM_UNITS(4), .UNIT_W(2), .SUM_W(20), .DATA_W(16), .ADDR_W(10), .OUT_BASE(48)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit result mux model: data follows unit_sel two clocks later.
  logic [19:0] unit_tbl [4];
  logic [19:0] ud_d1;
  always @(posedge clk) begin
    ud_d1         <= unit_tbl[bus.unit_sel];
    bus.unit_data <= ud_d1;
  end

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    int          at;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  wr_t mon_e;
  int  mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.RAM_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, no write expected (cycle %0d)",
                 bus.RAM_address, bus.RAM_din, cyc);
      end else begin
        mon_e = wr_q.pop_front();
        chk("wr_addr", 32'(bus.RAM_address), 32'(mon_e.addr));
        chk("wr_data", 32'(bus.RAM_din), 32'(mon_e.data));
        chk("wr_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, none expected (cycle %0d)", cyc);
      end else begin
        mon_d = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_d));
      end
    end
  end

  task automatic set_tbl(input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] c, input logic [19:0] d);
    unit_tbl[0] = a;
    unit_tbl[1] = b;
    unit_tbl[2] = c;
    unit_tbl[3] = d;
  endtask

  // exp4 packs the four expected words, unit 0 in the low 16 bits.
  task automatic push_run(input int base, input int c0, input logic [63:0] exp4, input int nwr,
                          input bit want_done);
    wr_t e;
    for (int k = 0; k < nwr; k++) begin
      e.addr = 10'(base + k);
      e.data = exp4[16*k +: 16];
      e.at   = c0 + 4*k + 3;
      wr_q.push_back(e);
    end
    if (want_done) done_q.push_back(c0 + 16);
  endtask

  // Returns at the negedge following E0 (cyc == c0).
  task automatic start_run(input logic [1:0] l, output int c0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = l;
    c0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.layer = 2'd0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((bus.busy || wr_q.size() != 0 || done_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL quiet_timeout: got %0d pending writes, %0d pending done, need 0",
               wr_q.size(), done_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_unit_sel"}, 32'(bus.unit_sel), 32'h0);
    chk({tag, "_addr"}, 32'(bus.RAM_address), 32'h0);
    chk({tag, "_din"}, 32'(bus.RAM_din), 32'h0);
    chk({tag, "_we"}, 32'(bus.RAM_we), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
  endtask

  initial begin
    int c0;
    int cnt;
    set_tbl(20'h0, 20'h0, 20'h0, 20'h0);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.layer = 2'd1;

    // Reset with start held: reset wins.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.layer = 2'd0;
    @(negedge clk);
    chk("post_reset_busy", 32'(bus.busy), 32'h0);

    // Layer 1 normal run.
    set_tbl(20'd5, 20'hFFFFD, 20'd100, 20'd0);
    start_run(2'd1, c0);
    push_run(52, c0, {16'h0000, 16'h0064, 16'hFFFD, 16'h0005}, 4, 1'b1);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", 32'(cnt), 32'd17);
    wait_quiet();

    // Saturation on layer 0.
    set_tbl(20'h40000, 20'h80000, 20'h07FFF, 20'hF8000);
    start_run(2'd0, c0);
    push_run(48, c0, {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}, 4, 1'b1);
    wait_quiet();

    // Invalid layer, then layer 2.
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.layer = 2'd0;
    chk("err_pulse", 32'(bus.err), 32'h1);
    chk("err_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("err_clear", 32'(bus.err), 32'h0);
    chk("err_idle_busy", 32'(bus.busy), 32'h0);
    set_tbl(20'd1, 20'd2, 20'd3, 20'd4);
    start_run(2'd2, c0);
    push_run(56, c0, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4, 1'b1);
    wait_quiet();

    // Reset at E6 of a layer-0 run: only address 48 lands.
    set_tbl(20'd7, 20'd8, 20'd9, 20'd10);
    start_run(2'd0, c0);
    push_run(48, c0, {16'h0, 16'h0, 16'h0, 16'h0007}, 1, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset_pending", 32'(wr_q.size()), 32'h0);
    set_tbl(20'd11, 20'd12, 20'd13, 20'd14);
    start_run(2'd0, c0);
    push_run(48, c0, {16'd14, 16'd13, 16'd12, 16'd11}, 4, 1'b1);
    wait_quiet();

    // start/layer=2 toggled while busy is ignored.
    set_tbl(20'd21, 20'd22, 20'd23, 20'd24);
    start_run(2'd0, c0);
    push_run(48, c0, {16'd24, 16'd23, 16'd22, 16'd21}, 4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = ~bus.start;
      bus.layer = 2'd2;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.layer = 2'd0;
    wait_quiet();

    // start held through DONE retriggers after one idle cycle.
    set_tbl(20'd31, 20'd32, 20'd33, 20'd34);
    @(negedge clk);
    bus.start = 1'b1;
    bus.layer = 2'd0;
    c0 = cyc + 1;
    push_run(48, c0, {16'd34, 16'd33, 16'd32, 16'd31}, 4, 1'b1);
    push_run(48, c0 + 18, {16'd34, 16'd33, 16'd32, 16'd31}, 4, 1'b1);
    repeat (17) @(negedge clk);
    chk("retrig_busy_done", 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk("retrig_busy_gap", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("retrig_busy_again", 32'(bus.busy), 32'h1);
    bus.start = 1'b0;
    wait_quiet();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
